// File: rtl/fetch_buffer_pkg.sv
// Shared packet type, lane count and default depth for the fetch buffer slice.
package fetch_buffer_pkg;

  localparam int N        = 2;
  localparam int FB_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } IF_ID_PACKET;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// DEPTH x IF_ID_PACKET storage for the fetch buffer: W write ports, W async read ports, no reset.
module fetch_buffer_ram
  import fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = FB_DEPTH,
  parameter  int W     = N,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic [W-1:0]              wr_en,
  input  logic [W-1:0][PTR_W-1:0]   wr_addr,
  input  IF_ID_PACKET [W-1:0]       wr_data,
  input  logic [W-1:0][PTR_W-1:0]   rd_addr,
  output IF_ID_PACKET [W-1:0]       rd_data
);

  IF_ID_PACKET mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < W; i++) begin
      if (wr_en[i]) begin
        mem[wr_addr[i]] <= wr_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < W; i++) begin
      rd_data[i] = mem[rd_addr[i]];
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// W-wide in-order instruction queue between IF and decode; flushed on squash.
// Optional same-cycle enq->deq bypass when FETCH_BUFFER_BYPASS_EN is defined.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter  int DEPTH = FB_DEPTH,
  parameter  int W     = N,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                squash,
  input  IF_ID_PACKET [W-1:0] enq_packet,
  input  logic [W-1:0]        enq_valid,
  output logic                enq_ready,
  output IF_ID_PACKET [W-1:0] deq_packet,
  output logic [W-1:0]        deq_valid,
  input  logic [CNT_W-1:0]    deq_count,
  output logic [OCC_W-1:0]    occupancy
);

  logic [PTR_W-1:0]          head, tail, head_nxt, tail_nxt;
  logic [OCC_W-1:0]          occ_nxt;
  logic                      accept;
  IF_ID_PACKET [W-1:0]       comp;
  logic [W-1:0]              wr_en;
  logic [W-1:0][PTR_W-1:0]   wr_addr;
  IF_ID_PACKET [W-1:0]       wr_data;
  logic [W-1:0][PTR_W-1:0]   rd_addr;
  IF_ID_PACKET [W-1:0]       rd_data;
  int                        n_in, push_total, occ_i, avail, pop, stored_pop, byp_pop;

  fetch_buffer_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Lanes are compacted so stored entries stay contiguous; bypassed lanes sit behind stored ones
  // and are consumed first from the stored side, so only the unpopped tail of comp is written.
  always_comb begin
    enq_ready  = (DEPTH - int'(occupancy)) >= W;
    accept     = enq_ready && !squash && reset_n;
    comp       = '0;
    n_in       = 0;
    for (int i = 0; i < W; i++) begin
      if (enq_valid[i]) begin
        for (int k = 0; k < W; k++) begin
          if (k == n_in) comp[k] = enq_packet[i];
        end
        n_in = n_in + 1;
      end
    end
    push_total = accept ? n_in : 0;
    occ_i      = int'(occupancy);

    deq_packet = '0;
    deq_valid  = '0;
    avail      = 0;
    for (int i = 0; i < W; i++) begin
      rd_addr[i] = head + PTR_W'(i);
      if (i < occ_i) begin
        deq_packet[i]       = rd_data[i];
        deq_packet[i].valid = 1'b1;
        deq_valid[i]        = 1'b1;
        avail               = avail + 1;
      end
`ifdef FETCH_BUFFER_BYPASS_EN
      else if (occ_i < W && !squash) begin
        for (int j = 0; j < W; j++) begin
          if (j == i - occ_i && j < push_total) begin
            deq_packet[i]       = comp[j];
            deq_packet[i].valid = 1'b1;
            deq_valid[i]        = 1'b1;
            avail               = avail + 1;
          end
        end
      end
`endif
    end

    pop        = min_int(int'(deq_count), avail);
    stored_pop = min_int(pop, occ_i);
    byp_pop    = pop - stored_pop;

    for (int k = 0; k < W; k++) begin
      wr_en[k]   = 1'b0;
      wr_data[k] = '0;
      wr_addr[k] = tail + PTR_W'(k);
      for (int j = 0; j < W; j++) begin
        if (j == byp_pop + k && j < push_total) begin
          wr_en[k]   = 1'b1;
          wr_data[k] = comp[j];
        end
      end
    end

    head_nxt = head + PTR_W'(stored_pop);
    tail_nxt = tail + PTR_W'(push_total - byp_pop);
    occ_nxt  = OCC_W'(occ_i + push_total - pop);
  end

  // Squash wins over any push or pop in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else if (squash) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      head      <= head_nxt;
      tail      <= tail_nxt;
      occupancy <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a queue scoreboard; honours FETCH_BUFFER_BYPASS_EN.
`timescale 1ns/1ps
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int DEPTH = FB_DEPTH;
  localparam int W     = N;
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset_n;
  logic                squash;
  IF_ID_PACKET [W-1:0] enq_packet;
  logic [W-1:0]        enq_valid;
  logic                enq_ready;
  IF_ID_PACKET [W-1:0] deq_packet;
  logic [W-1:0]        deq_valid;
  logic [1:0]          deq_count;
  logic [3:0]          occupancy;

  int          compared   = 0;
  int          mismatched = 0;
  IF_ID_PACKET sb[$];

  fetch_buffer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .squash     (squash),
    .enq_packet (enq_packet),
    .enq_valid  (enq_valid),
    .enq_ready  (enq_ready),
    .deq_packet (deq_packet),
    .deq_valid  (deq_valid),
    .deq_count  (deq_count),
    .occupancy  (occupancy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  // Incoming .valid is deliberately 0 so the forced output valid bit is exercised.
  function automatic IF_ID_PACKET mk_pkt(input logic [31:0] pc);
    IF_ID_PACKET p;
    p.valid = 1'b0;
    p.inst  = pc ^ 32'h1357_9BDF;
    p.pc    = pc;
    p.npc   = pc + 32'd4;
    return p;
  endfunction

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle, check the pre-edge outputs against the scoreboard, then advance the model.
  task automatic apply_stimulus(input string name, input logic [1:0] ev,
                                input logic [31:0] pc0, input logic [31:0] pc1,
                                input logic [1:0] dc, input logic sq);
    IF_ID_PACKET inc[$];
    IF_ID_PACKET vis[$];
    logic        exp_ready;
    logic        acc;
    int          n_pop;
    enq_valid     = ev;
    enq_packet[0] = mk_pkt(pc0);
    enq_packet[1] = mk_pkt(pc1);
    deq_count     = dc;
    squash        = sq;
    #1;
    if (ev[0]) inc.push_back(mk_pkt(pc0));
    if (ev[1]) inc.push_back(mk_pkt(pc1));
    exp_ready = (DEPTH - sb.size()) >= W;
    acc       = exp_ready && !sq;
    vis       = sb;
    if (BYPASS && sb.size() < W && acc) begin
      foreach (inc[k]) vis.push_back(inc[k]);
    end
    for (int i = 0; i < W; i++) begin
      IF_ID_PACKET e;
      logic        ev_i;
      e    = '0;
      ev_i = 1'b0;
      if (i < vis.size()) begin
        e       = vis[i];
        e.valid = 1'b1;
        ev_i    = 1'b1;
      end
      check_output($sformatf("%s deq_valid[%0d]", name, i), 128'(deq_valid[i]), 128'(ev_i));
      check_output($sformatf("%s deq_packet[%0d]", name, i), 128'(deq_packet[i]), 128'(e));
    end
    check_output({name, " enq_ready"}, 128'(enq_ready), 128'(exp_ready));
    check_output({name, " occupancy"}, 128'(occupancy), 128'(sb.size()));
    if (sq) begin
      sb.delete();
    end else begin
      if (acc) foreach (inc[k]) sb.push_back(inc[k]);
      n_pop = min_int(int'(dc), min_int(vis.size(), W));
      repeat (n_pop) void'(sb.pop_front());
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset_n   = 1'b0;
    squash    = 1'b0;
    enq_valid = '0;
    enq_packet = '0;
    deq_count = '0;
    repeat (2) @(negedge clock);
    check_output("reset occupancy", 128'(occupancy), 128'(0));
    check_output("reset enq_ready", 128'(enq_ready), 128'(1));
    check_output("reset deq_valid", 128'(deq_valid), 128'(0));
    reset_n = 1'b1;

    apply_stimulus("t1 push",      2'b11, 32'h00, 32'h04, 2'd0, 1'b0);
    apply_stimulus("t2 fill a",    2'b11, 32'h08, 32'h0C, 2'd0, 1'b0);
    apply_stimulus("t2 fill b",    2'b11, 32'h10, 32'h14, 2'd0, 1'b0);
    apply_stimulus("t2 fill c",    2'b11, 32'h18, 32'h1C, 2'd0, 1'b0);
    apply_stimulus("t2 full drop", 2'b11, 32'h20, 32'h24, 2'd0, 1'b0);
    apply_stimulus("t2 pop2",      2'b00, 32'h00, 32'h00, 2'd2, 1'b0);
    apply_stimulus("t3 pp a",      2'b11, 32'h28, 32'h2C, 2'd2, 1'b0);
    apply_stimulus("t3 pp b",      2'b11, 32'h30, 32'h34, 2'd2, 1'b0);
    apply_stimulus("t3 wrap",      2'b11, 32'h38, 32'h3C, 2'd2, 1'b0);
    apply_stimulus("t3 lane1",     2'b10, 32'h40, 32'h44, 2'd0, 1'b0);
    apply_stimulus("t3 occ7 drop", 2'b11, 32'h48, 32'h4C, 2'd0, 1'b0);
    apply_stimulus("t4 drain a",   2'b00, 32'h00, 32'h00, 2'd2, 1'b0);
    apply_stimulus("t4 drain b",   2'b00, 32'h00, 32'h00, 2'd2, 1'b0);
    apply_stimulus("t4 drain c",   2'b00, 32'h00, 32'h00, 2'd2, 1'b0);
    apply_stimulus("t4 clamp",     2'b00, 32'h00, 32'h00, 2'd2, 1'b0);
    apply_stimulus("t4 empty",     2'b00, 32'h00, 32'h00, 2'd2, 1'b0);
    apply_stimulus("t5 fill a",    2'b11, 32'h50, 32'h54, 2'd0, 1'b0);
    apply_stimulus("t5 fill b",    2'b11, 32'h58, 32'h5C, 2'd0, 1'b0);
    apply_stimulus("t5 lane0",     2'b01, 32'h60, 32'h64, 2'd0, 1'b0);
    apply_stimulus("t5 squash",    2'b11, 32'h68, 32'h6C, 2'd2, 1'b1);
    apply_stimulus("t5 after",     2'b00, 32'h00, 32'h00, 2'd0, 1'b0);
    apply_stimulus("t6 bypass",    2'b11, 32'h70, 32'h74, 2'd1, 1'b0);
    apply_stimulus("t6 after",     2'b00, 32'h00, 32'h00, 2'd0, 1'b0);
    apply_stimulus("t6 drain",     2'b00, 32'h00, 32'h00, 2'd2, 1'b0);
    apply_stimulus("rst pre",      2'b11, 32'h80, 32'h84, 2'd0, 1'b0);

    enq_valid     = 2'b11;
    enq_packet[0] = mk_pkt(32'h88);
    enq_packet[1] = mk_pkt(32'h8C);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check_output("midrst occupancy", 128'(occupancy), 128'(0));
    check_output("midrst deq_valid", 128'(deq_valid), 128'(0));
    check_output("midrst enq_ready", 128'(enq_ready), 128'(1));
    @(negedge clock);
    reset_n   = 1'b1;
    enq_valid = '0;

    apply_stimulus("rst empty",    2'b00, 32'h00, 32'h00, 2'd0, 1'b0);
    apply_stimulus("rst push",     2'b11, 32'h90, 32'h94, 2'd0, 1'b0);
    apply_stimulus("rst pop",      2'b00, 32'h00, 32'h00, 2'd2, 1'b0);
    apply_stimulus("final",        2'b00, 32'h00, 32'h00, 2'd0, 1'b0);

    $display("[TB] directed sequence complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
